// File: rtl/pipe_stall_flush_ctrl.sv
// Pipeline stall/flush controller: contiguous stall mask, multi-cycle exception flush
// with redirect PC, and a saturating stall counter. CTRL_STALL_WDOG_EN adds a stall watchdog.
module pipe_stall_flush_ctrl #(
  parameter int          STAGES       = 6,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter logic [31:0] ERET_TYPE    = 32'h0000000e,
  parameter int          CNT_W        = 32,
  parameter int          STALL_LIMIT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              excp_valid,
  input  logic [31:0]       excp_type,
  input  logic [31:0]       cp0_epc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_reg;
  logic [FC_W-1:0]   flush_cnt_reg;
  logic [31:0]       held_pc_reg;
  logic [CNT_W-1:0]  stall_cycles_reg;
  logic [STAGES-1:0] stall_mask;
  logic [31:0]       redirect_pc;

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be at least 1");
  end
  if (STALL_LIMIT < 1) begin : g_bad_stall_limit
    $error("STALL_LIMIT must be at least 1");
  end

  // Stage k freezes whenever it or any younger-indexed-higher stage requests a stall.
  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stall_mask
    assign stall_mask[gi] = |stallreq[STAGES-1:gi];
  end

  assign redirect_pc = (excp_type == ERET_TYPE) ? cp0_epc : EXC_VECTOR;

  always_comb begin
    flush  = 1'b0;
    new_pc = 32'h0;
    stall  = '0;
    if (!rst) begin
      if (state_reg == FLUSH) begin
        flush  = 1'b1;
        new_pc = held_pc_reg;
      end else if (excp_valid) begin
        flush  = 1'b1;
        new_pc = redirect_pc;
      end
      if (!flush) begin
        stall = stall_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      held_pc_reg   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (excp_valid) begin
            held_pc_reg <= redirect_pc;
            if (FLUSH_CYCLES > 1) begin
              state_reg     <= FLUSH;
              flush_cnt_reg <= FC_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          // New exceptions arriving here are intentionally dropped.
          flush_cnt_reg <= flush_cnt_reg - FC_W'(1);
          if (flush_cnt_reg == FC_W'(1)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_reg <= '0;
    end else if (stall != '0 && stall_cycles_reg != '1) begin
      stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_reg;

`ifdef CTRL_STALL_WDOG_EN
  localparam int WD_W = $clog2(STALL_LIMIT) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT    = WD_W'(STALL_LIMIT);
  localparam logic [WD_W-1:0] WD_LIMIT_M1 = WD_W'(STALL_LIMIT - 1);

  logic [WD_W-1:0] wdog_cnt_reg;
  logic            timeout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (stall == '0 || flush) begin
      wdog_cnt_reg <= '0;
    end else begin
      if (wdog_cnt_reg != WD_LIMIT) begin
        wdog_cnt_reg <= wdog_cnt_reg + WD_W'(1);
      end
      // The edge that brings the count to the limit raises the sticky flag.
      if (wdog_cnt_reg >= WD_LIMIT_M1) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_reg;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule
